nonce_search_ctrl: RTL and testbench
====================================

# nonce_search_ctrl

- Drives candidate nonces into the hash/validity stage and consumes its `validity_reg` result flag.
- Sits directly downstream of `validity_reg`.
- Sweeps nonces from 0 upward, one at a time, and waits a fixed hash latency for each.
- Stops on the first nonce judged valid, or when the nonce space is exhausted, and reports the outcome.

## Interface

Parameters:
- `NONCE_W`, 8 — nonce width; sweep covers 0 … 2^NONCE_W−1.
- `HASH_LAT`, 3 — cycles from nonce issue to the matching `validity_reg`. Legal range 1…15.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low; all state clears immediately on assertion.
- `start`  in  1  — begin a sweep; sampled only in IDLE or DONE.
- `validity_reg`  in  1  — validity flag from the upstream checker for the nonce currently issued.
- `nonce`  out  NONCE_W  — current candidate; held stable from ISSUE through CHECK.
- `nonce_valid`  out  1  — one-cycle pulse marking a new candidate.
- `busy`  out  1  — high in ISSUE, WAIT and CHECK.
- `done`  out  1  — high in DONE; held until the next accepted `start` or reset.
- `found`  out  1  — qualified by `done`; 1 = hit, 0 = exhausted.
- `result_nonce`  out  NONCE_W  — winning nonce when `found`; 0 otherwise.

## Operation

- **Reset values:** every output is 0, the state is IDLE, and the wait counter is 0.
- **States:** IDLE, ISSUE, WAIT, CHECK, DONE.
- **IDLE:** `start`=1 goes to ISSUE with `nonce`←0. Otherwise the FSM stays in IDLE.
- **ISSUE:** lasts one cycle with `nonce_valid`=1, and loads the wait counter with HASH_LAT−1.
  - If HASH_LAT=1, go straight to CHECK.
  - Otherwise go to WAIT.
- **WAIT:** decrement the counter each cycle; go to CHECK when the counter reaches 0.
- **CHECK:** sample `validity_reg` in this cycle.
  - If `validity_reg`=1: go to DONE with `found`←1 and `result_nonce`←`nonce`.
  - Else if `nonce` = 2^NONCE_W−1: go to DONE with `found`←0 and `result_nonce`←0.
  - Else: `nonce`←`nonce`+1 and go to ISSUE.
- **DONE:** `done`=1, and `found`/`result_nonce` are held.
  - `start`=1 clears `done`, `found` and `result_nonce`, sets `nonce`←0 and goes to ISSUE.
- **`start` while busy:** ignored; no queuing.
- **`validity_reg` outside CHECK:** ignored. Glitches during WAIT have no effect.
- **Nonce arithmetic:** unsigned, NONCE_W bits. The wrap case (max+1) is never reached, because exhaustion is detected before the increment.
- **Reset mid-sweep:** immediate return to IDLE with all outputs 0. No partial result is retained.
- **`start` and `reset` together:** reset wins.

## Timing

- `start` high at edge k (IDLE) → ISSUE during cycle k+1, with `nonce`=0 and `nonce_valid`=1.
- Let the nonce issue cycle be t. Then CHECK occurs in cycle t+HASH_LAT.
  - The upstream stage must present `validity_reg` for that nonce in cycle t+HASH_LAT.
- **Per-nonce cost:** HASH_LAT+1 cycles.
- **Hit latency:** `done` rises in cycle t+HASH_LAT+1 for a hit on the nonce issued at t.
- **Full exhaustive sweep:** 2^NONCE_W·(HASH_LAT+1) cycles from the first ISSUE to the last CHECK. `done` rises one cycle later.
- `nonce` is constant for all HASH_LAT+1 cycles of a candidate. It changes only on the CHECK→ISSUE transition.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

Shared package `nonce_search_pkg` holds:
- the state encoding constants `ST_IDLE`, `ST_ISSUE`, `ST_WAIT`, `ST_CHECK`, `ST_DONE` (3 bits);
- the default values for `NONCE_W` and `HASH_LAT`.

Sub-modules:
- `lat_counter`: a 4-bit loadable down-counter with `load`, `load_val` and a `zero` flag, driving the WAIT→CHECK exit. Instantiated once.
- Everything else (FSM, nonce register, result registers) lives in the top module.

The bench instantiates `nonce_search_ctrl`, `validity_reg` and a stimulus module in the same way the existing benches do. The stimulus module also delays `validity_reg` to match HASH_LAT.

## Test plan

1. **Reset:** hold `reset`=0 for 3 cycles, then release → all outputs 0, `busy`=0, FSM in IDLE; `start`=0 keeps it there.
2. **Early hit:** NONCE_W=8, HASH_LAT=3, model asserts validity for nonce 5 → `done`=1 and `found`=1 with `result_nonce`=5. `done` rises exactly 6·4+1=25 cycles after the `start` edge, and `nonce_valid` pulses exactly 6 times.
3. **Exhaustion:** NONCE_W=4, HASH_LAT=2, `validity_reg` never asserted → after 16 candidates, `done`=1 with `found`=0 and `result_nonce`=0; the last `nonce` is 15 with no wrap.
4. **Glitch immunity:** `validity_reg` pulsed during WAIT for nonce 2 but low in CHECK, then valid for nonce 3 → `result_nonce`=3.
5. **Reset mid-sweep:** `reset` asserted during WAIT for nonce 7 → outputs 0 on the same edge; a new `start` restarts from nonce 0.
6. **Restart and ignored start:** `start` from DONE (`result_nonce`=5) → `done`, `found` and `result_nonce` clear and the sweep restarts at nonce 0. `start` pulsed while busy → no effect on sequence or timing.

Source files
------------

// File: rtl/nonce_search_pkg.sv
// Shared definitions for the nonce search controller: FSM encoding and
// default sweep geometry.
package nonce_search_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NONCE_W_DEF  = 8;
    localparam int HASH_LAT_DEF = 3;

endpackage

// File: rtl/nonce_search_ctrl_if.sv
// Handshake bundle between the nonce search controller and its
// environment (start request, validity flag, candidate and result).
interface nonce_search_ctrl_if #(
    parameter int NONCE_W = nonce_search_pkg::NONCE_W_DEF
) ();

    logic               start;
    logic               validity_reg;
    logic [NONCE_W-1:0] nonce;
    logic               nonce_valid;
    logic               busy;
    logic               done;
    logic               found;
    logic [NONCE_W-1:0] result_nonce;

    // Controller side
    modport master (
        input  start,
        input  validity_reg,
        output nonce,
        output nonce_valid,
        output busy,
        output done,
        output found,
        output result_nonce
    );

    // Environment side (request source and hash/validity stage)
    modport slave (
        output start,
        output validity_reg,
        input  nonce,
        input  nonce_valid,
        input  busy,
        input  done,
        input  found,
        input  result_nonce
    );

endinterface

// File: rtl/lat_counter.sv
// 4-bit loadable down-counter timing the hash latency of one candidate.
// `zero` is raised on the cycle in which the count steps down to 0, so the
// FSM can leave WAIT exactly HASH_LAT cycles after the issue cycle.
module lat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: load has priority, otherwise count down and stick at 0
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q <= 4'd1);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: sweeps nonces from 0 upward, waits HASH_LAT
// cycles per candidate, and stops on the first valid nonce or exhaustion.
// All outputs are registered.
module nonce_search_ctrl
    import nonce_search_pkg::*;
#(
    parameter int NONCE_W  = NONCE_W_DEF,
    parameter int HASH_LAT = HASH_LAT_DEF
) (
    input logic                 clk,
    input logic                 reset,
    nonce_search_ctrl_if.master bus
);

    localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);
    localparam logic [3:0]         LAT_LOAD  = 4'(HASH_LAT - 1);

    state_t             state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] result_q, result_d;
    logic               found_q, found_d;
    logic               nonce_valid_q, nonce_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cnt_load;
    logic               cnt_zero;

    lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .zero     (cnt_zero)
    );

    // Next-state, nonce/result update and registered-output decode
    always_comb begin
        state_d  = state_q;
        nonce_d  = nonce_q;
        found_d  = found_q;
        result_d = result_q;
        cnt_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    nonce_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_load = 1'b1;
                state_d  = (HASH_LAT == 1) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bus.validity_reg) begin
                    found_d  = 1'b1;
                    result_d = nonce_q;
                    state_d  = ST_DONE;
                end else if (nonce_q == '1) begin
                    // exhaustion is caught here, so the nonce never wraps
                    found_d  = 1'b0;
                    result_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    nonce_d = nonce_q + NONCE_ONE;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    found_d  = 1'b0;
                    result_d = '0;
                    nonce_d  = '0;
                    state_d  = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // status flags are decoded from the next state so they register
        // in step with the state they describe
        nonce_valid_d = (state_d == ST_ISSUE);
        busy_d        = (state_d == ST_ISSUE) || (state_d == ST_WAIT) ||
                        (state_d == ST_CHECK);
        done_d        = (state_d == ST_DONE);
    end

    // State, candidate, result and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            nonce_q       <= '0;
            result_q      <= '0;
            found_q       <= 1'b0;
            nonce_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            result_q      <= result_d;
            found_q       <= found_d;
            nonce_valid_q <= nonce_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.nonce        = nonce_q;
    assign bus.nonce_valid  = nonce_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.found        = found_q;
    assign bus.result_nonce = result_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl: two instances (8-bit/lat 3 and
// 4-bit/lat 2), a delayed validity model per instance and a result
// scoreboard filled at start and drained when done rises.
module tb_nonce_search_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nonce_search_ctrl_if #(.NONCE_W(8)) if8 ();
    nonce_search_ctrl_if #(.NONCE_W(4)) if4 ();

    nonce_search_ctrl #(.NONCE_W(8), .HASH_LAT(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.master)
    );

    nonce_search_ctrl #(.NONCE_W(4), .HASH_LAT(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.master)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       found;
        logic [7:0] result;
    } exp_t;

    exp_t sb8[$];
    exp_t sb4[$];

    int   target8 = -1;
    int   target4 = -1;
    logic glitch8 = 1'b0;
    logic [2:0] vp8;
    logic [1:0] vp4;

    // Hash/validity stage model: flag for the target nonce appears HASH_LAT
    // cycles after its issue cycle
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            vp8 <= '0;
            vp4 <= '0;
        end else begin
            vp8 <= {vp8[1:0], if8.nonce_valid && (int'(if8.nonce) == target8)};
            vp4 <= {vp4[0], if4.nonce_valid && (int'(if4.nonce) == target4)};
        end
    end

    assign if8.validity_reg = vp8[2] | glitch8;
    assign if4.validity_reg = vp4[1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a sweep on dut8 and follow it to done. exp_lat is the spec cycle
    // count from the start edge to the cycle in which done is high.
    task automatic run8(input string tag, input int exp_lat, input int exp_pulses,
                        input int inject_at, input int glitch_nonce);
        int   pulses;
        int   expn;
        int   lat;
        int   gph;
        logic seen;
        exp_t e;
        @(negedge clk);
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        check({tag, "_first_nv"}, 32'(if8.nonce_valid), 1);
        check({tag, "_first_nonce"}, 32'(if8.nonce), 0);
        check({tag, "_done_clr"}, 32'(if8.done), 0);
        check({tag, "_found_clr"}, 32'(if8.found), 0);
        check({tag, "_res_clr"}, 32'(if8.result_nonce), 0);
        pulses = 1;
        expn   = 1;
        lat    = 0;
        gph    = 0;
        seen   = 1'b0;
        for (int n = 1; n <= 3000 && !seen; n++) begin
            if (n == inject_at) if8.start = 1'b1;
            if (gph == 1) begin
                glitch8 = 1'b1;
                gph     = 2;
            end else if (gph == 2) begin
                glitch8 = 1'b0;
                gph     = 3;
            end
            @(posedge clk);
            #1;
            if8.start = 1'b0;
            if (if8.nonce_valid) begin
                check({tag, "_nonce_seq"}, 32'(if8.nonce), 32'(expn));
                expn++;
                pulses++;
                if (gph == 0 && int'(if8.nonce) == glitch_nonce) gph = 1;
            end
            if (if8.done) begin
                seen = 1'b1;
                lat  = n + 1;
            end
        end
        glitch8 = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        if (sb8.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb8.pop_front();
            check({tag, "_found"}, 32'(if8.found), 32'(e.found));
            check({tag, "_result"}, 32'(if8.result_nonce), 32'(e.result));
        end
    endtask

    task automatic run4(input string tag, input int exp_lat, input int exp_pulses);
        int   pulses;
        int   expn;
        int   lat;
        logic seen;
        exp_t e;
        @(negedge clk);
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        check({tag, "_first_nv"}, 32'(if4.nonce_valid), 1);
        check({tag, "_first_nonce"}, 32'(if4.nonce), 0);
        pulses = 1;
        expn   = 1;
        lat    = 0;
        seen   = 1'b0;
        for (int n = 1; n <= 3000 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (if4.nonce_valid) begin
                check({tag, "_nonce_seq"}, 32'(if4.nonce), 32'(expn));
                expn++;
                pulses++;
            end
            if (if4.done) begin
                seen = 1'b1;
                lat  = n + 1;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        if (sb4.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb4.pop_front();
            check({tag, "_found"}, 32'(if4.found), 32'(e.found));
            check({tag, "_result"}, 32'(if4.result_nonce), 32'(e.result));
        end
    endtask

    task automatic check_idle8(input string tag);
        check({tag, "_nonce"}, 32'(if8.nonce), 0);
        check({tag, "_nv"}, 32'(if8.nonce_valid), 0);
        check({tag, "_busy"}, 32'(if8.busy), 0);
        check({tag, "_done"}, 32'(if8.done), 0);
        check({tag, "_found"}, 32'(if8.found), 0);
        check({tag, "_res"}, 32'(if8.result_nonce), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic hit7;

        // Reset held for 3 cycles
        reset     = 1'b0;
        if8.start = 1'b0;
        if4.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle8("rst");
        check("rst4_busy", 32'(if4.busy), 0);
        check("rst4_done", 32'(if4.done), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle8("idle");
        check("idle4_busy", 32'(if4.busy), 0);

        // Early hit on nonce 5
        target8 = 5;
        sb8.push_back('{1'b1, 8'd5});
        run8("hit5", 25, 6, 0, -1);
        repeat (3) @(negedge clk);
        check("hit5_done_hold", 32'(if8.done), 1);
        check("hit5_res_hold", 32'(if8.result_nonce), 5);
        check("hit5_busy_low", 32'(if8.busy), 0);

        // Restart from DONE; glitch in WAIT of nonce 2; start pulsed while busy
        target8 = 3;
        sb8.push_back('{1'b1, 8'd3});
        run8("glitch", 17, 4, 6, 2);

        // Exhaustion on the 4-bit instance
        target4 = -1;
        sb4.push_back('{1'b0, 8'd0});
        run4("exh", 49, 16);
        check("exh_last_nonce", 32'(if4.nonce), 15);

        // Reset during WAIT of nonce 7
        target8 = -1;
        @(negedge clk);
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        hit7 = 1'b0;
        for (int n = 0; n < 100 && !hit7; n++) begin
            @(posedge clk);
            #1;
            if (if8.nonce_valid && if8.nonce == 8'd7) hit7 = 1'b1;
        end
        check("mid_reach7", 32'(hit7), 1);
        @(posedge clk);
        #2;
        check("mid_busy_pre", 32'(if8.busy), 1);
        reset = 1'b0;
        #1;
        check_idle8("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle8("mid_idle");

        // Fresh sweep after the aborted one starts from 0
        target8 = 2;
        sb8.push_back('{1'b1, 8'd2});
        run8("restart", 13, 3, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
